// File: rtl/mirfak_multiplier.sv
// Iterative 32x32 RV32M multiplier (MUL/MULH/MULHSU/MULHU), BITS_PER_CYCLE multiplier bits per RUN cycle.
// Handshake: enable is held until the one-cycle ack; ack blocks re-capture for its own cycle; abort flushes to IDLE.
module mirfak_multiplier #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] mult_op1,
    input  logic [31:0] mult_op2,
    input  logic [1:0]  mult_cmd,
    input  logic        mult_enable,
    input  logic        mult_abort,
    output logic [31:0] mult_result,
    output logic        mult_ack,
    output logic [1:0]  dbg_state
);

    localparam int ITER = 32 / BITS_PER_CYCLE;
    localparam int CW   = 6;
    localparam logic [CW-1:0] LAST_CNT = CW'(ITER - 1);

    localparam logic [1:0] CMD_MUL   = 2'b00;
    localparam logic [1:0] CMD_MULH  = 2'b01;
    localparam logic [1:0] CMD_MULHU = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    cmd_q, cmd_d;
    logic [63:0]   mcand_q, mcand_d;
    logic [31:0]   mplier_q, mplier_d;
    logic          outsign_q, outsign_d;
    logic [63:0]   acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   result_q, result_d;
    logic          ack_q, ack_d;

    logic          op1_neg, op2_neg;
    logic [31:0]   op1_mag, op2_mag;
    logic [63:0]   partial;
    logic [63:0]   product;

    always_comb begin
        // MULHU treats both operands unsigned; MULHSU only op1 signed.
        op1_neg = (mult_cmd != CMD_MULHU) && mult_op1[31];
        op2_neg = ((mult_cmd == CMD_MUL) || (mult_cmd == CMD_MULH)) && mult_op2[31];
        op1_mag = op1_neg ? (~mult_op1 + 32'd1) : mult_op1;
        op2_mag = op2_neg ? (~mult_op2 + 32'd1) : mult_op2;

        // The multiplicand is pre-shifted to the current weight, so the
        // partial product is a plain sum of its shifted copies.
        partial = 64'd0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (mplier_q[i]) begin
                partial = partial + (mcand_q << i);
            end
        end
        product = outsign_q ? (~acc_q + 64'd1) : acc_q;
    end

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        outsign_d = outsign_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        ack_d     = 1'b0;

        if (mult_abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (mult_enable && !ack_q) begin
                        cmd_d     = mult_cmd;
                        mcand_d   = {32'd0, op1_mag};
                        mplier_d  = op2_mag;
                        outsign_d = op1_neg ^ op2_neg;
                        acc_d     = 64'd0;
                        cnt_d     = '0;
                        state_d   = S_RUN;
                    end
                end
                S_RUN: begin
                    acc_d    = acc_q + partial;
                    mcand_d  = mcand_q << BITS_PER_CYCLE;
                    mplier_d = mplier_q >> BITS_PER_CYCLE;
                    cnt_d    = cnt_q + CW'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    result_d = (cmd_q == CMD_MUL) ? product[31:0] : product[63:32];
                    ack_d    = 1'b1;
                    state_d  = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            cmd_q     <= 2'b00;
            mcand_q   <= 64'd0;
            mplier_q  <= 32'd0;
            outsign_q <= 1'b0;
            acc_q     <= 64'd0;
            cnt_q     <= '0;
            result_q  <= 32'd0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            outsign_q <= outsign_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            ack_q     <= ack_d;
        end
    end

    assign mult_result = result_q;
    assign mult_ack    = ack_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_mirfak_multiplier.sv
// Bench for mirfak_multiplier: three instances (1, 2 and 4 bits per cycle) share operands
// and run side by side; a queue-based scoreboard checks result and ack timing per instance.
module tb_mirfak_multiplier;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] op1, op2;
  logic [1:0]  cmd;
  logic [2:0]  en, abort;
  logic [31:0] res [3];
  logic [2:0]  ack;
  logic [1:0]  st [3];

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  // Each entry: {expected ack cycle, expected result}.
  logic [63:0] exp_q [3][$];
  logic [31:0] last_res [3];
  logic [2:0]  ack_prev;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    mirfak_multiplier #(.BITS_PER_CYCLE(1 << k)) u_dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .mult_op1   (op1),
      .mult_op2   (op2),
      .mult_cmd   (cmd),
      .mult_enable(en[k]),
      .mult_abort (abort[k]),
      .mult_result(res[k]),
      .mult_ack   (ack[k]),
      .dbg_state  (st[k])
    );
  end

  // Reference: extend each operand to 64 bits by its signedness and take the product mod 2^64.
  function automatic logic [31:0] ref_mul(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = (c != 2'b11 && a[31]) ? {32'hFFFF_FFFF, a} : {32'd0, a};
    eb = (c[1] == 1'b0 && b[31]) ? {32'hFFFF_FFFF, b} : {32'd0, b};
    p  = ea * eb;
    return (c == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever an instance raises ack.
  always @(negedge clk) begin
    if (rst) begin
      ack_prev = 3'b000;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (ack[k]) begin
          if (ack_prev[k]) begin
            check($sformatf("ack_width_b%0d", 1 << k), 32'd1, 32'd0);
          end else if (exp_q[k].size() == 0) begin
            check($sformatf("spurious_ack_b%0d", 1 << k), 32'd1, 32'd0);
          end else begin
            logic [63:0] e;
            e = exp_q[k].pop_front();
            check($sformatf("latency_b%0d", 1 << k), 32'(cyc), e[63:32]);
            check($sformatf("result_b%0d", 1 << k), res[k], e[31:0]);
          end
        end
        ack_prev[k] = ack[k];
      end
    end
  end

  task automatic scramble();
    op1 = $urandom;
    op2 = $urandom;
    cmd = 2'($urandom_range(0, 3));
  endtask

  // Issue one operation to all instances; hold_extra keeps enable up through the ack cycle.
  task automatic run_op(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b, input bit hold_extra);
    logic [2:0] seen;
    logic [31:0] r;
    seen = 3'b000;
    @(negedge clk);
    op1 = a; op2 = b; cmd = c; en = 3'b111;
    r = ref_mul(c, a, b);
    for (int k = 0; k < 3; k++) begin
      exp_q[k].push_back({32'(cyc + 2 + (32 >> k)), r});
      last_res[k] = r;
    end
    for (int t = 0; t < 60 && en != 3'b000; t++) begin
      @(negedge clk);
      scramble();
      for (int k = 0; k < 3; k++) begin
        if (en[k]) begin
          if (seen[k]) en[k] = 1'b0;
          else if (ack[k]) begin
            if (hold_extra) seen[k] = 1'b1;
            else en[k] = 1'b0;
          end
        end
      end
    end
    check("ack_timeout", {29'd0, en}, 32'd0);
    en = 3'b000;
  endtask

  // Edge 1 is the capture edge; instance k sees abort (with enable still high) on edge d[k].
  task automatic abort_op(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b,
                          input int d0, input int d1, input int d2);
    int d [3];
    int maxd;
    d[0] = d0; d[1] = d1; d[2] = d2;
    maxd = (d0 > d1) ? d0 : d1;
    maxd = (maxd > d2) ? maxd : d2;
    for (int i = 1; i <= maxd; i++) begin
      @(negedge clk);
      if (i == 1) begin
        op1 = a; op2 = b; cmd = c;
      end else begin
        scramble();
      end
      for (int k = 0; k < 3; k++) begin
        en[k]    = (i <= d[k]);
        abort[k] = (i == d[k]);
      end
    end
    @(negedge clk);
    en = 3'b000; abort = 3'b000;
    repeat (40) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("abort_result_b%0d", 1 << k), res[k], last_res[k]);
      check($sformatf("abort_idle_b%0d", 1 << k), {30'd0, st[k]}, 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1; en = 3'b000; abort = 3'b000;
    op1 = 32'd0; op2 = 32'd0; cmd = 2'b00;
    ack_prev = 3'b000;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("reset_ack", {31'd0, ack[k]}, 32'd0);
      check("reset_result", res[k], 32'd0);
      check("reset_state", {30'd0, st[k]}, 32'd0);
      last_res[k] = 32'd0;
    end
    rst = 1'b0;

    run_op(2'b00, 32'd7, 32'd6, 1'b1);
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) check("no_restart_idle", {30'd0, st[k]}, 32'd0);

    run_op(2'b01, 32'h8000_0000, 32'h8000_0000, 1'b0);
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0);
    run_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 1'b0);
    run_op(2'b01, 32'hFFFF_FFFD, 32'd5, 1'b0);
    run_op(2'b01, 32'd0, 32'h8000_0000, 1'b0);

    abort_op(2'b11, 32'h1234_5678, 32'h9ABC_DEF0, 11, 7, 6);
    run_op(2'b11, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    abort_op(2'b00, 32'd5, 32'd7, 34, 18, 10);
    abort_op(2'b00, 32'd9, 32'd9, 1, 1, 1);

    @(negedge clk);
    op1 = 32'd11; op2 = 32'd13; cmd = 2'b00; en = 3'b111;
    repeat (6) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      check("async_rst_ack", {31'd0, ack[k]}, 32'd0);
      check("async_rst_result", res[k], 32'd0);
      check("async_rst_state", {30'd0, st[k]}, 32'd0);
      last_res[k] = 32'd0;
    end
    @(negedge clk);
    en = 3'b000;
    rst = 1'b0;
    run_op(2'b00, 32'd3, 32'd4, 1'b0);

    for (int n = 0; n < 25; n++) begin
      logic [1:0] c;
      logic [31:0] a, b;
      c = 2'($urandom_range(0, 3));
      a = rand_opnd();
      b = rand_opnd();
      run_op(c, a, b, 1'($urandom_range(0, 1)));
    end

    repeat (5) @(negedge clk);
    for (int k = 0; k < 3; k++) check("queue_empty", 32'(exp_q[k].size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/mirfak_multiplier.md
Name: mirfak_multiplier

Overview:
Iterative 32x32 multiplier implementing the RV32M MUL/MULH/MULHSU/MULHU group. It is the multiplicative counterpart to the pipeline's iterative divider and shares its enable/abort/ack handshake. It sits beside the divider in the execute stage; the pipeline holds the request until the one-cycle acknowledge.

Parameters:
BITS_PER_CYCLE, 1, multiplier bits retired per RUN cycle; legal values are 1, 2 and 4. ITER = 32/BITS_PER_CYCLE.

Ports:
clk_i  input  1  clock; all state updates on the rising edge
rst_i  input  1  asynchronous, active-high reset
mult_op1  input  32  rs1 operand (multiplicand)
mult_op2  input  32  rs2 operand (multiplier)
mult_cmd  input  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
mult_enable  input  1  request; held high by the pipeline until mult_ack
mult_abort  input  1  synchronous flush (exception or branch kill)
mult_result  output  32  product slice; valid while mult_ack=1, held afterwards
mult_ack  output  1  one-cycle completion pulse

Behaviour:
- Reset (async, rst_i=1): state=IDLE, mult_ack=0, mult_result=0; all internal registers cleared. This applies at any time, including mid-RUN. No ack is ever produced for an interrupted operation.
- FSM states are IDLE, RUN and DONE.
- IDLE -> RUN when mult_enable && !mult_ack && !mult_abort. On that edge the block captures:
  - the cmd;
  - op1 magnitude: negated if op1[31]=1 and cmd is MUL, MULH or MULHSU;
  - op2 magnitude: negated if op2[31]=1 and cmd is MUL or MULH;
  - outsign = XOR of the signs treated as signed; 0 for MULHU;
  - 64-bit accumulator = 0; iteration counter = 0.
- Operands are sampled only on the capture edge. Changes to op1, op2 or cmd during RUN are ignored.
- RUN, each cycle:
  - add (op1 magnitude x the next BITS_PER_CYCLE LSBs of op2 magnitude), shifted to the current weight, into the accumulator;
  - advance the multiplier by BITS_PER_CYCLE;
  - counter +1.
  - After ITER RUN cycles -> DONE.
- Accumulator width is 64 bits, unsigned magnitude. Overflow is impossible since both magnitudes are at most 2^31 for signed operands and at most 2^32-1 for unsigned operands.
- 0x80000000 signed has magnitude 2^31, represented correctly in 32 bits unsigned.
- DONE, single cycle: P = outsign ? -acc : acc, 64-bit two's complement. mult_result <= (cmd==MUL) ? P[31:0] : P[63:32]. mult_ack <= 1. Next state IDLE.
- mult_ack is high for exactly one cycle. It blocks re-capture in the IDLE cycle where ack=1. The pipeline must deassert enable (or present a new op) on the cycle after ack. If enable is still high after that, a new operation starts.
- Latency, counted from the edge that first samples enable=1 in IDLE:
  - capture = edge 1;
  - RUN = edges 2..ITER+1;
  - ack rises on edge ITER+2 (34 for BITS_PER_CYCLE=1, 10 for 4).
- Abort (sync, highest priority after reset): on an edge with mult_abort=1, state=IDLE and mult_ack=0. mult_result is unchanged. If abort and a completion (DONE) coincide, abort wins: no ack and result not updated. If abort and enable coincide in IDLE, there is no capture.
- A zero operand needs no special case; the result is 0 with outsign forced irrelevant, since -0=0.
- mult_result holds its last value until the next DONE or reset.

Test Plan:
1. MUL op1=7, op2=6, enable held -> ack pulses on edge 34 (B=1) for exactly 1 cycle; result=0x0000002A. The following cycle ack=0, and no restart while enable is dropped.
2. MULH 0x80000000 x 0x80000000 -> result 0x40000000. MUL of the same operands -> 0x00000000.
3. op1=0xFFFFFFFF, op2=0xFFFFFFFF:
   - MULHSU -> 0xFFFFFFFF;
   - MULHU -> 0xFFFFFFFE;
   - MULH -> 0x00000000;
   - MUL -> 0x00000001.
4. MUL/MULH with op1=0xFFFFFFFD (-3), op2=5 -> MUL 0xFFFFFFF1, MULH 0xFFFFFFFF. op1=0, op2=0x80000000 under MULH -> 0x00000000.
5. Abort:
   - assert abort 10 cycles after capture -> no ack ever, result unchanged;
   - re-issue MULHU 0x12345678 x 0x9ABCDEF0 -> result 0x0B00EA4E after full latency;
   - abort on the DONE edge -> no ack.
6. Assert rst_i asynchronously mid-RUN (between edges) -> ack=0 and result=0 immediately. After release, a new MUL 3x4 -> 0x0000000C. Repeat tests 1-4 with BITS_PER_CYCLE=2 and 4, checking latency 18 and 10.
